// File: rtl/rv_pipe_hazard.sv
`default_nettype none
// ============================================================================
// Module   : rv_pipe_hazard
// Purpose  : Hazard and forwarding controller for the pipelined RV32 core.
//            It tracks the destination registers of in-flight instructions in
//            the DEPTH stages after ID. From these it generates load-use
//            stalls, branch-redirect flushes and multi-cycle-EX holds, and it
//            registers the EX operand forwarding selects.
// Ports    : clk, rst_n (async, active low)
//            id_*        - decode-stage instruction fields
//            ex_busy     - multi-cycle EX operation still running
//            ex_redirect - taken branch/jump resolved in EX
//            hold_front, hold_ex, bubble_ex, flush_front - pipeline controls
//            fwd_rs1_sel, fwd_rs2_sel - 0=regfile, k=output of stage k
//            (RV_HAZ_PERF_EN) perf_clr, perf_stall, perf_flush, perf_busy
// Options  : RV_HAZ_PERF_EN - adds saturating performance counters
// Revision : 1.0 - initial release
// ============================================================================
module rv_pipe_hazard #(
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int RA_W       = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [RA_W-1:0]          id_rs1,
    input  logic [RA_W-1:0]          id_rs2,
    input  logic                     id_rs1_used,
    input  logic                     id_rs2_used,
    input  logic [RA_W-1:0]          id_rd,
    input  logic                     id_reg_write,
    input  logic                     id_mem_read,
    input  logic                     ex_busy,
    input  logic                     ex_redirect,
    output logic                     hold_front,
    output logic                     hold_ex,
    output logic                     bubble_ex,
    output logic                     flush_front,
    output logic [$clog2(DEPTH)-1:0] fwd_rs1_sel,
    output logic [$clog2(DEPTH)-1:0] fwd_rs2_sel
`ifdef RV_HAZ_PERF_EN
    ,
    input  logic                     perf_clr,
    output logic [31:0]              perf_stall,
    output logic [31:0]              perf_flush,
    output logic [31:0]              perf_busy
`endif
);

    localparam int SEL_W = $clog2(DEPTH);

    // Tracking entries: entry k describes the instruction in stage k.
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_wr;
    logic [DEPTH-1:0] r_ld;
    logic [RA_W-1:0]  r_rd [DEPTH];

    logic [SEL_W-1:0] r_sel1;
    logic [SEL_W-1:0] r_sel2;

    logic             w_lu1;
    logic             w_lu2;
    logic [SEL_W-1:0] w_nsel1;
    logic [SEL_W-1:0] w_nsel2;
    logic             w_redir;
    logic             w_stall;
    logic             w_load;

    // Search from the oldest entry down so the youngest match is the last
    // one written and therefore wins.
    always_comb begin
        w_lu1   = 1'b0;
        w_lu2   = 1'b0;
        w_nsel1 = '0;
        w_nsel2 = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (r_valid[k] && r_wr[k] && (r_rd[k] != '0) &&
                (r_rd[k] == id_rs1) && id_rs1_used) begin
                w_lu1   = r_ld[k] && (k < LOAD_STAGE);
                w_nsel1 = (k <= DEPTH - 2) ? SEL_W'(k + 1) : '0;
            end
            if (r_valid[k] && r_wr[k] && (r_rd[k] != '0) &&
                (r_rd[k] == id_rs2) && id_rs2_used) begin
                w_lu2   = r_ld[k] && (k < LOAD_STAGE);
                w_nsel2 = (k <= DEPTH - 2) ? SEL_W'(k + 1) : '0;
            end
        end
    end

    // Priority: busy > redirect > load-use > advance.
    assign w_redir = ex_redirect & ~ex_busy;
    assign w_stall = id_valid & (w_lu1 | w_lu2) & ~ex_busy & ~w_redir;
    assign w_load  = id_valid & ~ex_busy & ~w_redir & ~w_stall;

    // Outputs are forced low while reset is asserted, independent of the
    // live EX inputs.
    assign hold_front  = rst_n & (ex_busy | w_stall);
    assign hold_ex     = rst_n & ex_busy;
    assign bubble_ex   = rst_n & (w_redir | w_stall);
    assign flush_front = rst_n & w_redir;
    assign fwd_rs1_sel = r_sel1;
    assign fwd_rs2_sel = r_sel2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_wr    <= '0;
            r_ld    <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_rd[k] <= '0;
            end
            r_sel1 <= '0;
            r_sel2 <= '0;
        end else if (ex_busy) begin
            // EX holds its instruction; MA receives a bubble, the rest drain.
            r_valid[1] <= 1'b0;
            r_wr[1]    <= 1'b0;
            r_ld[1]    <= 1'b0;
            r_rd[1]    <= '0;
            for (int k = 2; k < DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_wr[k]    <= r_wr[k-1];
                r_ld[k]    <= r_ld[k-1];
                r_rd[k]    <= r_rd[k-1];
            end
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_wr[k]    <= r_wr[k-1];
                r_ld[k]    <= r_ld[k-1];
                r_rd[k]    <= r_rd[k-1];
            end
            r_valid[0] <= w_load;
            r_wr[0]    <= w_load & id_reg_write;
            r_ld[0]    <= w_load & id_mem_read;
            r_rd[0]    <= w_load ? id_rd : '0;
            // A bubble entering EX carries no forwarding.
            r_sel1 <= w_load ? w_nsel1 : '0;
            r_sel2 <= w_load ? w_nsel2 : '0;
        end
    end

`ifdef RV_HAZ_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
            r_perf_busy  <= '0;
        end else if (perf_clr) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
            r_perf_busy  <= '0;
        end else begin
            if (w_stall && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_redir && (r_perf_flush != 32'hFFFF_FFFF)) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
            if (ex_busy && (r_perf_busy != 32'hFFFF_FFFF)) begin
                r_perf_busy <= r_perf_busy + 32'd1;
            end
        end
    end

    assign perf_stall = r_perf_stall;
    assign perf_flush = r_perf_flush;
    assign perf_busy  = r_perf_busy;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv_pipe_hazard.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_pipe_hazard
// Purpose  : Directed self-checking bench for rv_pipe_hazard (DEPTH=3,
//            LOAD_STAGE=1). Inputs change 1 ns after the rising edge and
//            outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_pipe_hazard;

    localparam int DEPTH      = 3;
    localparam int LOAD_STAGE = 1;
    localparam int RA_W       = 5;
    localparam int SEL_W      = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid;
    logic [RA_W-1:0]  id_rs1;
    logic [RA_W-1:0]  id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [RA_W-1:0]  id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             ex_busy;
    logic             ex_redirect;
    logic             hold_front;
    logic             hold_ex;
    logic             bubble_ex;
    logic             flush_front;
    logic [SEL_W-1:0] fwd_rs1_sel;
    logic [SEL_W-1:0] fwd_rs2_sel;
`ifdef RV_HAZ_PERF_EN
    logic             perf_clr = 1'b0;
    logic [31:0]      perf_stall;
    logic [31:0]      perf_flush;
    logic [31:0]      perf_busy;
`endif

    // {hold_front, hold_ex, bubble_ex, flush_front}
    logic [3:0] w_ctrl;
    assign w_ctrl = {hold_front, hold_ex, bubble_ex, flush_front};

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rv_pipe_hazard #(
        .DEPTH      (DEPTH),
        .LOAD_STAGE (LOAD_STAGE),
        .RA_W       (RA_W)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .ex_busy      (ex_busy),
        .ex_redirect  (ex_redirect),
        .hold_front   (hold_front),
        .hold_ex      (hold_ex),
        .bubble_ex    (bubble_ex),
        .flush_front  (flush_front),
        .fwd_rs1_sel  (fwd_rs1_sel),
        .fwd_rs2_sel  (fwd_rs2_sel)
`ifdef RV_HAZ_PERF_EN
        ,
        .perf_clr     (perf_clr),
        .perf_stall   (perf_stall),
        .perf_flush   (perf_flush),
        .perf_busy    (perf_busy)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic id_set(input logic v, input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2,
                          input logic u1, input logic u2, input logic [RA_W-1:0] rd,
                          input logic wr, input logic mr);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rs1_used  = u1;
        id_rs2_used  = u2;
        id_rd        = rd;
        id_reg_write = wr;
        id_mem_read  = mr;
    endtask

    task automatic idle();
        id_set(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (DEPTH) next_cyc();
    endtask

    initial begin
        // ---- reset: outputs low even with busy/redirect asserted ----
        ex_busy     = 1'b1;
        ex_redirect = 1'b1;
        id_set(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        @(negedge clk);
        chk("rst_ctrl", 32'(w_ctrl), 32'h0);
        chk("rst_sel1", 32'(fwd_rs1_sel), 32'd0);
        chk("rst_sel2", 32'(fwd_rs2_sel), 32'd0);
        ex_busy     = 1'b0;
        ex_redirect = 1'b0;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        next_cyc();

        // ---- ALU dependency: addi x5,x0,1 ; add x6,x5,x5 ----
        id_set(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
        @(negedge clk);
        chk("alu_addi_ctrl", 32'(w_ctrl), 32'h0);
        next_cyc();
        id_set(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        @(negedge clk);
        chk("alu_add_ctrl", 32'(w_ctrl), 32'h0);
        next_cyc();
        idle();
        @(negedge clk);
        chk("alu_sel1", 32'(fwd_rs1_sel), 32'd1);
        chk("alu_sel2", 32'(fwd_rs2_sel), 32'd1);
        next_cyc();
        @(negedge clk);
        chk("alu_bubble_sel1", 32'(fwd_rs1_sel), 32'd0);
        drain();

        // ---- load-use: lw x7,0(x1) ; add x8,x7,x1 ----
        id_set(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
        @(negedge clk);
        chk("lu_lw_ctrl", 32'(w_ctrl), 32'h0);
        next_cyc();
        id_set(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        @(negedge clk);
        chk("lu_stall_ctrl", 32'(w_ctrl), 32'b1010);
        next_cyc();
        @(negedge clk);
        chk("lu_release_ctrl", 32'(w_ctrl), 32'h0);
        chk("lu_bubble_sel1", 32'(fwd_rs1_sel), 32'd0);
        next_cyc();
        idle();
        @(negedge clk);
        chk("lu_sel1", 32'(fwd_rs1_sel), 32'd2);
        chk("lu_sel2", 32'(fwd_rs2_sel), 32'd0);
        drain();

        // ---- x0 destination: lw x0,0(x2) ; add x9,x0,x0 ----
        id_set(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
        next_cyc();
        id_set(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        @(negedge clk);
        chk("x0_ctrl", 32'(w_ctrl), 32'h0);
        next_cyc();
        idle();
        @(negedge clk);
        chk("x0_sel1", 32'(fwd_rs1_sel), 32'd0);
        chk("x0_sel2", 32'(fwd_rs2_sel), 32'd0);
        drain();

        // ---- redirect in the load-use cycle ----
        id_set(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
        next_cyc();
        id_set(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        ex_redirect = 1'b1;
        @(negedge clk);
        chk("redir_ctrl", 32'(w_ctrl), 32'b0011);
        next_cyc();
        ex_redirect = 1'b0;
        // add x11,x8,x0: would forward from EX if add x8 had not been killed
        id_set(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0);
        @(negedge clk);
        chk("redir_next_ctrl", 32'(w_ctrl), 32'h0);
        chk("redir_bubble_sel1", 32'(fwd_rs1_sel), 32'd0);
        next_cyc();
        idle();
        @(negedge clk);
        chk("redir_no_fwd", 32'(fwd_rs1_sel), 32'd0);
        drain();

        // ---- busy for 3 cycles with an ALU result in MA ----
        id_set(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);   // addi x5
        next_cyc();
        id_set(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0);  // add x12,x5
        @(negedge clk);
        chk("busy_pre_ctrl", 32'(w_ctrl), 32'h0);
        next_cyc();
        ex_busy     = 1'b1;
        ex_redirect = 1'b1;                                       // ignored
        id_set(1'b1, 5'd5, 5'd12, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0); // add x13,x5,x12
        @(negedge clk);
        chk("busy1_ctrl", 32'(w_ctrl), 32'b1100);
        chk("busy1_sel1", 32'(fwd_rs1_sel), 32'd1);
        next_cyc();
        ex_redirect = 1'b0;
        @(negedge clk);
        chk("busy2_ctrl", 32'(w_ctrl), 32'b1100);
        chk("busy2_sel1_hold", 32'(fwd_rs1_sel), 32'd1);
        next_cyc();
        @(negedge clk);
        chk("busy3_ctrl", 32'(w_ctrl), 32'b1100);
        next_cyc();
        ex_busy = 1'b0;
        @(negedge clk);
        chk("busy_done_ctrl", 32'(w_ctrl), 32'h0);
        next_cyc();
        idle();
        @(negedge clk);
        chk("busy_after_sel1", 32'(fwd_rs1_sel), 32'd0);
        chk("busy_after_sel2", 32'(fwd_rs2_sel), 32'd1);
        drain();

`ifdef RV_HAZ_PERF_EN
        chk("perf_stall_cnt", perf_stall, 32'd1);
        chk("perf_flush_cnt", perf_flush, 32'd1);
        chk("perf_busy_cnt", perf_busy, 32'd3);
`endif

        // ---- reset asserted in the middle of a load-use stall ----
        id_set(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
        next_cyc();
        id_set(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        @(negedge clk);
        chk("rst_pre_stall", 32'(w_ctrl), 32'b1010);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", 32'(w_ctrl), 32'h0);
        chk("rst_mid_sel1", 32'(fwd_rs1_sel), 32'd0);
`ifdef RV_HAZ_PERF_EN
        chk("rst_perf_stall", perf_stall, 32'd0);
        chk("rst_perf_flush", perf_flush, 32'd0);
        chk("rst_perf_busy", perf_busy, 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_ctrl", 32'(w_ctrl), 32'h0);
        rst_n = 1'b1;
        next_cyc();
        @(negedge clk);
        chk("rst_after_ctrl", 32'(w_ctrl), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
